// File: rtl/prism_pkg.sv
// -----------------------------------------------------------------------------
// prism_pkg
// Shared definitions for the PRISM SIT programmer:
//   SIT_ADDR_LO / SIT_ADDR_HI : debug addresses of the SIT low / high word
//   SIT_ADDR_NONE             : address driven while idle or done
//   prism_prog_state_t        : programmer FSM state encoding
//   hi_word_mask()            : mask keeping only entry bits [WIDTH-1:32]
// -----------------------------------------------------------------------------
package prism_pkg;

    localparam logic [5:0] SIT_ADDR_LO   = 6'h10;
    localparam logic [5:0] SIT_ADDR_HI   = 6'h14;
    localparam logic [5:0] SIT_ADDR_NONE = 6'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WR_LO,
        ST_GAP_LO,
        ST_WR_HI,
        ST_GAP_HI,
        ST_VERIFY_LO,
        ST_VERIFY_HI,
        ST_DONE
    } prism_prog_state_t;

    // Upper 32 bits of a WIDTH-bit all-ones mask; bits at or above WIDTH in
    // the last received byte are dropped through this.
    function automatic logic [31:0] hi_word_mask(input int width);
        logic [63:0] m;
        if (width >= 64) m = '1;
        else             m = (64'd1 << width) - 64'd1;
        return m[63:32];
    endfunction

endpackage

// File: rtl/prism_byte_assembler.sv
// -----------------------------------------------------------------------------
// prism_byte_assembler
// Collects NBYTES little-endian bytes into a 64-bit word.
//   clk, rst     : clock, synchronous active-high reset
//   clear_i      : restart assembly (byte counter and word zeroed)
//   accept_i     : byte_i is taken this cycle at the current byte position
//   byte_i       : incoming byte
//   last_o       : the next accepted byte completes the word
//   lo_next_o    : word bits [31:0] as they will be after this cycle
//   hi_o         : registered word bits [63:32]
// -----------------------------------------------------------------------------
module prism_byte_assembler #(
    parameter int NBYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        last_o,
    output logic [31:0] lo_next_o,
    output logic [31:0] hi_o
);

    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

    logic [2:0]  cnt_q,  cnt_d;
    logic [63:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (accept_i) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_i;
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign last_o    = (cnt_q == LAST_IDX);
    // The low-word write is launched on the same edge that takes the final
    // byte, so the top needs the post-update value.
    assign lo_next_o = word_d[31:0];
    assign hi_o      = word_q[63:32];

endmodule

// File: rtl/prism_sit_programmer.sv
// -----------------------------------------------------------------------------
// prism_sit_programmer
// Loads DEPTH entries of WIDTH bits from a byte stream into the PRISM SIT via
// paired debug writes (low word at 0x10, high word at 0x14).
// Optional read-back check: define PRISM_SIT_VERIFY_EN.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a load (honoured only in IDLE or DONE)
//   s_valid/s_data/s_ready : byte stream, LSB first; a byte moves on a cycle
//                   where s_valid && s_ready; s_valid without s_ready is
//                   ignored and s_ready never waits on s_valid
//   debug_addr/debug_wr/debug_wdata : single-cycle write strobe to the SIT
//   debug_rdata   : combinational SIT read-back at debug_addr
//   busy, done, error : status levels
// All outputs are registered from the next-state decode. state_q holds the
// FSM state (prism_prog_state_t) for observation.
// -----------------------------------------------------------------------------
module prism_sit_programmer
    import prism_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 2,
    parameter int WR_GAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [5:0]  debug_addr,
    output logic        debug_wr,
    output logic [31:0] debug_wdata,
    input  logic [31:0] debug_rdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          NBYTES     = (WIDTH + 7) / 8;
    localparam int          EW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [EW-1:0] LAST_ENTRY = EW'(DEPTH - 1);
    localparam logic [2:0]  GAP_LAST   = 3'(WR_GAP - 1);
    localparam logic [31:0] HI_MASK    = hi_word_mask(WIDTH);

    prism_prog_state_t state_q, state_d;
    logic [EW-1:0] entry_q, entry_d;
    logic [2:0]    gap_q, gap_d;
    logic          s_ready_q, s_ready_d;
    logic [5:0]    addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          asm_clear, asm_accept, asm_last;
    logic [31:0]   asm_lo_next, asm_hi, hi_word;

`ifdef PRISM_SIT_VERIFY_EN
    logic [31:0]   ref_lo_q, ref_lo_d, ref_hi_q, ref_hi_d;
    logic          error_q, error_d;
`endif

    assign asm_accept = s_valid && s_ready_q;
    assign hi_word    = asm_hi & HI_MASK;

    prism_byte_assembler #(.NBYTES(NBYTES)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (asm_clear),
        .accept_i  (asm_accept),
        .byte_i    (s_data),
        .last_o    (asm_last),
        .lo_next_o (asm_lo_next),
        .hi_o      (asm_hi)
    );

    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        gap_d     = gap_q;
        asm_clear = 1'b0;
`ifdef PRISM_SIT_VERIFY_EN
        ref_lo_d  = ref_lo_q;
        ref_hi_d  = ref_hi_q;
        error_d   = error_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    entry_d   = '0;
                    asm_clear = 1'b1;
                    state_d   = ST_COLLECT;
`ifdef PRISM_SIT_VERIFY_EN
                    error_d   = 1'b0;
`endif
                end
            end
            ST_COLLECT: begin
                if (asm_accept && asm_last) state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
                gap_d   = '0;
                state_d = ST_GAP_LO;
            end
            ST_GAP_LO: begin
                if (gap_q == GAP_LAST) state_d = ST_WR_HI;
                else                   gap_d   = gap_q + 3'd1;
            end
            ST_WR_HI: begin
                gap_d   = '0;
                state_d = ST_GAP_HI;
            end
            ST_GAP_HI: begin
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + 3'd1;
                end else if (entry_q != LAST_ENTRY) begin
                    entry_d   = entry_q + EW'(1);
                    asm_clear = 1'b1;
                    state_d   = ST_COLLECT;
                end else begin
`ifdef PRISM_SIT_VERIFY_EN
                    state_d = ST_VERIFY_LO;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef PRISM_SIT_VERIFY_EN
            // debug_addr already points at the word being checked here.
            ST_VERIFY_LO: begin
                if (debug_rdata != ref_lo_q) error_d = 1'b1;
                state_d = ST_VERIFY_HI;
            end
            ST_VERIFY_HI: begin
                if (debug_rdata != ref_hi_q) error_d = 1'b1;
                state_d = ST_DONE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef PRISM_SIT_VERIFY_EN
        // The SIT shows the first-loaded entry on read-back after the load.
        if (entry_q == '0) begin
            if (state_d == ST_WR_LO && state_q == ST_COLLECT) ref_lo_d = asm_lo_next;
            if (state_d == ST_WR_HI && state_q == ST_GAP_LO)  ref_hi_d = hi_word;
        end
`endif

        // Output registers follow the state being entered.
        s_ready_d = (state_d == ST_COLLECT);
        wr_d      = (state_d == ST_WR_LO) || (state_d == ST_WR_HI);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_d)
            ST_WR_LO: begin
                addr_d  = SIT_ADDR_LO;
                wdata_d = asm_lo_next;
            end
            ST_WR_HI: begin
                addr_d  = SIT_ADDR_HI;
                wdata_d = hi_word;
            end
            ST_VERIFY_LO:     addr_d = SIT_ADDR_LO;
            ST_VERIFY_HI:     addr_d = SIT_ADDR_HI;
            ST_IDLE, ST_DONE: addr_d = SIT_ADDR_NONE;
            default:          addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            entry_q   <= '0;
            gap_q     <= '0;
            s_ready_q <= 1'b0;
            addr_q    <= SIT_ADDR_NONE;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            gap_q     <= gap_d;
            s_ready_q <= s_ready_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef PRISM_SIT_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_lo_q <= '0;
            ref_hi_q <= '0;
            error_q  <= 1'b0;
        end else begin
            ref_lo_q <= ref_lo_d;
            ref_hi_q <= ref_hi_d;
            error_q  <= error_d;
        end
    end
    assign error = error_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^debug_rdata;
    assign error        = 1'b0;
`endif

    assign s_ready     = s_ready_q;
    assign debug_addr  = addr_q;
    assign debug_wr    = wr_q;
    assign debug_wdata = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_prism_sit_programmer.sv
// -----------------------------------------------------------------------------
// tb_prism_sit_programmer
// Three programmer instances (64b x2 gap1, 40b x1 gap1, 37b x3 gap3) share one
// clock and reset. Expected SIT writes are built from the byte stream with
// plain arithmetic; a negedge monitor collects the strobes actually issued.
// -----------------------------------------------------------------------------
module tb_prism_sit_programmer;

`ifdef PRISM_SIT_VERIFY_EN
    localparam int   VER_EXTRA = 2;
    localparam logic VER_ERR   = 1'b1;
`else
    localparam int   VER_EXTRA = 0;
    localparam logic VER_ERR   = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        start   [3];
    logic        s_valid [3];
    logic [7:0]  s_data  [3];
    logic        s_ready [3];
    logic [5:0]  d_addr  [3];
    logic        d_wr    [3];
    logic [31:0] d_wdata [3];
    logic [31:0] d_rdata [3];
    logic        busy    [3];
    logic        done    [3];
    logic        error   [3];
    logic [31:0] sit_lo  [3];
    logic [31:0] sit_hi  [3];
    logic        corrupt [3];

    function automatic int w_of(input int d);
        case (d) 0: return 64; 1: return 40; default: return 37; endcase
    endfunction
    function automatic int dp_of(input int d);
        case (d) 0: return 2; 1: return 1; default: return 3; endcase
    endfunction
    function automatic int gp_of(input int d);
        case (d) 0: return 1; 1: return 1; default: return 3; endcase
    endfunction

    prism_sit_programmer #(.WIDTH(64), .DEPTH(2), .WR_GAP(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .s_valid(s_valid[0]), .s_data(s_data[0]),
        .s_ready(s_ready[0]), .debug_addr(d_addr[0]), .debug_wr(d_wr[0]),
        .debug_wdata(d_wdata[0]), .debug_rdata(d_rdata[0]), .busy(busy[0]),
        .done(done[0]), .error(error[0]));
    prism_sit_programmer #(.WIDTH(40), .DEPTH(1), .WR_GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .s_valid(s_valid[1]), .s_data(s_data[1]),
        .s_ready(s_ready[1]), .debug_addr(d_addr[1]), .debug_wr(d_wr[1]),
        .debug_wdata(d_wdata[1]), .debug_rdata(d_rdata[1]), .busy(busy[1]),
        .done(done[1]), .error(error[1]));
    prism_sit_programmer #(.WIDTH(37), .DEPTH(3), .WR_GAP(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .s_valid(s_valid[2]), .s_data(s_data[2]),
        .s_ready(s_ready[2]), .debug_addr(d_addr[2]), .debug_wr(d_wr[2]),
        .debug_wdata(d_wdata[2]), .debug_rdata(d_rdata[2]), .busy(busy[2]),
        .done(done[2]), .error(error[2]));

    // SIT read-back model: shows the first-loaded entry, optionally corrupted.
    for (genvar g = 0; g < 3; g++) begin : g_sit
        assign d_rdata[g] = (d_addr[g] == 6'h10) ? sit_lo[g] :
                            (d_addr[g] == 6'h14) ? (sit_hi[g] ^ {31'd0, corrupt[g]}) : 32'd0;
    end

    // ---------------- scoreboard state ----------------
    logic [37:0] exp_q [$];
    logic [37:0] obs_q [$];
    int          obs_cyc [$];
    int          obs_d [$];
    logic [7:0]  stim_q [$];
    logic        prev_wr [3];
    int          wide_cnt = 0;
    int          n_asserts = 0;
    int          n_fail = 0;
    int          t0 = 0;
    logic        busy_rel1, busy_done, err_done;

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (d_wr[g] === 1'b1) begin
                obs_q.push_back({d_addr[g], d_wdata[g]});
                obs_cyc.push_back(cyc);
                obs_d.push_back(g);
                if (prev_wr[g] === 1'b1) wide_cnt++;
            end
            prev_wr[g] = d_wr[g];
        end
    end

    // ---------------- reference model ----------------
    task automatic build_expected(input int d);
        int nb;
        logic [63:0] val;
        nb = (w_of(d) + 7) / 8;
        exp_q.delete();
        for (int e = 0; e < dp_of(d); e++) begin
            val = 64'd0;
            for (int i = 0; i < nb; i++) val = val | (64'(stim_q[e * nb + i]) << (8 * i));
            if (w_of(d) < 64) val = val & ((64'd1 << w_of(d)) - 64'd1);
            exp_q.push_back({6'h10, val[31:0]});
            exp_q.push_back({6'h14, val[63:32]});
            if (e == 0) begin
                sit_lo[d] = val[31:0];
                sit_hi[d] = val[63:32];
            end
        end
        corrupt[d] = 1'b0;
    endtask

    function automatic int exp_done(input int d);
        return 1 + dp_of(d) * ((w_of(d) + 7) / 8 + 2 * (1 + gp_of(d))) + VER_EXTRA;
    endfunction

    task automatic rand_stim(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // ---------------- driver ----------------
    // Pulses start, streams stim_q (optionally with s_valid low every other
    // cycle, optionally with extra start pulses while busy) and waits for done.
    task automatic run_load(input int d, input bit toggle, input bit pulses, output int t_done);
        int idx;
        int rel;
        bit phase;
        obs_q.delete(); obs_cyc.delete(); obs_d.delete();
        wide_cnt = 0;
        @(negedge clk);
        start[d] = 1'b1;
        t0 = cyc;
        idx = 0;
        phase = 1'b0;
        t_done = -1;
        for (int n = 0; n < 3000 && t_done < 0; n++) begin
            @(negedge clk);
            rel = cyc - t0;
            start[d] = pulses && (rel == 5 || rel == 10 || rel == 22);
            if (idx < stim_q.size() && !(toggle && phase)) begin
                s_valid[d] = 1'b1;
                s_data[d]  = stim_q[idx];
                if (s_ready[d]) idx++;
            end else begin
                s_valid[d] = 1'b0;
            end
            phase = !phase;
            if (rel == 1) busy_rel1 = busy[d];
            if (done[d] === 1'b1) begin
                t_done    = rel;
                busy_done = busy[d];
                err_done  = error[d];
            end
        end
        s_valid[d] = 1'b0;
        start[d]   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_asserts++;
            if ({s_ready[d], d_addr[d], d_wr[d], d_wdata[d], busy[d], done[d], error[d]} !== 43'd0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: got rdy=%b addr=%h wr=%b wdata=%h busy=%b done=%b err=%b, expected all zero",
                         d, s_ready[d], d_addr[d], d_wr[d], d_wdata[d], busy[d], done[d], error[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_64();
        int t_done;
        stim_q.delete();
        for (int i = 1; i <= 16; i++) stim_q.push_back(8'(i));
        build_expected(0);
        run_load(0, 1'b0, 1'b0, t_done);
        n_asserts++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL load64 write count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_asserts++;
            if (obs_q[i] !== exp_q[i] || obs_d[i] != 0) begin
                n_fail++; $display("FAIL load64 write %0d: got dut%0d %h, expected %h", i, obs_d[i], obs_q[i], exp_q[i]);
            end
            n_asserts++;
            if (obs_cyc[i] - t0 != 9 + 12 * (i / 2) + 2 * (i % 2)) begin
                n_fail++; $display("FAIL load64 strobe %0d cycle: got %0d, expected %0d", i, obs_cyc[i] - t0, 9 + 12 * (i / 2) + 2 * (i % 2));
            end
        end
        n_asserts++;
        if (t_done != 25 + VER_EXTRA) begin
            n_fail++; $display("FAIL load64 done cycle: got %0d, expected %0d", t_done, 25 + VER_EXTRA);
        end
        n_asserts++;
        if ({busy_rel1, busy_done, err_done} !== 3'b100) begin
            n_fail++; $display("FAIL load64 status: got busy1=%b busy_at_done=%b err=%b, expected 1 0 0", busy_rel1, busy_done, err_done);
        end
    endtask

    task automatic test_width40();
        int t_done;
        stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h5E};
        build_expected(1);
        run_load(1, 1'b0, 1'b0, t_done);
        n_asserts++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL width40 write count: got %0d, expected 2", obs_q.size());
        end
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            n_asserts++;
            if (obs_q[i] !== exp_q[i] || obs_d[i] != 1) begin
                n_fail++; $display("FAIL width40 write %0d: got dut%0d %h, expected %h", i, obs_d[i], obs_q[i], exp_q[i]);
            end
        end
        n_asserts++;
        if (t_done != exp_done(1) || err_done !== 1'b0) begin
            n_fail++; $display("FAIL width40 done: got cycle %0d err %b, expected cycle %0d err 0", t_done, err_done, exp_done(1));
        end
    endtask

    task automatic test_random_37();
        int t_done;
        for (int rep = 0; rep < 2; rep++) begin
            rand_stim(15);
            build_expected(2);
            run_load(2, 1'b0, 1'b0, t_done);
            n_asserts++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand37 write count: got %0d, expected %0d", obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_asserts++;
                if (obs_q[i] !== exp_q[i] || obs_d[i] != 2) begin
                    n_fail++; $display("FAIL rand37 write %0d: got dut%0d %h, expected %h", i, obs_d[i], obs_q[i], exp_q[i]);
                end
                if (i % 2 == 1) begin
                    n_asserts++;
                    if (obs_cyc[i] - obs_cyc[i - 1] != gp_of(2) + 1) begin
                        n_fail++; $display("FAIL rand37 lo-hi spacing %0d: got %0d, expected %0d", i, obs_cyc[i] - obs_cyc[i - 1], gp_of(2) + 1);
                    end
                end
            end
            n_asserts++;
            if (t_done != exp_done(2)) begin
                n_fail++; $display("FAIL rand37 done cycle: got %0d, expected %0d", t_done, exp_done(2));
            end
        end
    endtask

    task automatic test_toggle();
        int t_done;
        rand_stim(16);
        build_expected(0);
        run_load(0, 1'b1, 1'b0, t_done);
        n_asserts++;
        if (obs_q.size() != exp_q.size() || t_done < 0) begin
            n_fail++; $display("FAIL toggle write count/done: got %0d writes done %0d, expected %0d writes", obs_q.size(), t_done, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_asserts++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL toggle write %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
            if (i % 2 == 1) begin
                n_asserts++;
                if (obs_cyc[i] - obs_cyc[i - 1] != 2) begin
                    n_fail++; $display("FAIL toggle lo-hi spacing %0d: got %0d, expected 2", i, obs_cyc[i] - obs_cyc[i - 1]);
                end
            end
        end
        n_asserts++;
        if (wide_cnt != 0) begin
            n_fail++; $display("FAIL toggle strobe width: got %0d over-long strobes, expected 0", wide_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int t_done;
        rand_stim(16);
        build_expected(0);
        run_load(0, 1'b0, 1'b1, t_done);
        n_asserts++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL busy_start write count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_asserts++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL busy_start write %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_asserts++;
        if (t_done != 25 + VER_EXTRA) begin
            n_fail++; $display("FAIL busy_start done cycle: got %0d, expected %0d", t_done, 25 + VER_EXTRA);
        end
    endtask

    task automatic test_verify();
        int t_done;
        stim_q.delete();
        for (int i = 1; i <= 16; i++) stim_q.push_back(8'(i));
        build_expected(0);
        corrupt[0] = 1'b1;
        run_load(0, 1'b0, 1'b0, t_done);
        n_asserts++;
        if (t_done != 25 + VER_EXTRA || err_done !== VER_ERR) begin
            n_fail++; $display("FAIL verify corrupt: got done cycle %0d err %b, expected %0d err %b", t_done, err_done, 25 + VER_EXTRA, VER_ERR);
        end
        n_asserts++;
        if (error[0] !== VER_ERR || done[0] !== 1'b1) begin
            n_fail++; $display("FAIL verify hold: got err %b done %b, expected err %b done 1", error[0], done[0], VER_ERR);
        end
        corrupt[0] = 1'b0;
        run_load(0, 1'b0, 1'b0, t_done);
        n_asserts++;
        if (t_done != 25 + VER_EXTRA || err_done !== 1'b0) begin
            n_fail++; $display("FAIL verify clean: got done cycle %0d err %b, expected %0d err 0", t_done, err_done, 25 + VER_EXTRA);
        end
    endtask

    task automatic test_reset_mid();
        int  idx;
        int  t_done;
        bit  seen;
        rand_stim(16);
        @(negedge clk);
        start[0] = 1'b1;
        idx  = 0;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            start[0] = 1'b0;
            seen = (d_wr[0] === 1'b1);
            if (idx < stim_q.size()) begin
                s_valid[0] = 1'b1;
                s_data[0]  = stim_q[idx];
                if (s_ready[0]) idx++;
            end
        end
        // The cycle after the first low strobe is the low-word gap.
        @(negedge clk);
        s_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_asserts++;
        if (!seen || {s_ready[0], d_addr[0], d_wr[0], d_wdata[0], busy[0], done[0], error[0]} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: strobe_seen=%b rdy=%b addr=%h wr=%b wdata=%h busy=%b done=%b err=%b, expected all zero",
                     seen, s_ready[0], d_addr[0], d_wr[0], d_wdata[0], busy[0], done[0], error[0]);
        end
        rand_stim(16);
        build_expected(0);
        run_load(0, 1'b0, 1'b0, t_done);
        n_asserts++;
        if (obs_q.size() != exp_q.size() || t_done != 25 + VER_EXTRA) begin
            n_fail++; $display("FAIL reset_mid reload: got %0d writes done %0d, expected %0d writes done %0d", obs_q.size(), t_done, exp_q.size(), 25 + VER_EXTRA);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_asserts++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL reset_mid write %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0; s_valid[d] = 1'b0; s_data[d] = 8'd0;
            sit_lo[d] = 32'd0; sit_hi[d] = 32'd0; corrupt[d] = 1'b0; prev_wr[d] = 1'b0;
        end
        test_reset();
        test_load_64();
        test_width40();
        test_random_37();
        test_toggle();
        test_start_while_busy();
        test_verify();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
